// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
//
// Word-organised data memory addressed by byte address, with a registered
// access port and a self-timed clear engine that zeroes the whole array.
//
// Optional feature macro: BYTE_WRITE_EN
//   defined   -> adds the 'be' byte-strobe port; writes merge only the
//                strobed bytes into the stored word
//   undefined -> full-word writes, no 'be' port
//
// Ports
//   clk       in   single clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset (starts a full clear)
//   dir       in   byte address of the access
//   en        in   1 = write, 0 = read
//   dataIn    in   write data
//   clr       in   request a full-memory clear (only looked at in IDLE)
//   be        in   byte write strobes (BYTE_WRITE_EN only)
//   dataOut   out  registered access data (write-first on writes)
//   zeroFlag  out  registered, 1 when dataOut is zero
//   busy      out  clear engine running; accesses are ignored
//   alignErr  out  registered, 1 when the last accepted access was misaligned
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   dir,
    input  logic                en,
    input  logic [DATA_W-1:0]   dataIn,
    input  logic                clr,
`ifdef BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic [DATA_W-1:0]   dataOut,
    output logic                zeroFlag,
    output logic                busy,
    output logic                alignErr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  nextCnt;
    logic              clearWe;
    logic              accept;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  offset;
    logic              aligned;
    logic              takeAccess;
    logic [DATA_W-1:0] memRead;
    logic [DATA_W-1:0] writeWord;
    logic [DATA_W-1:0] accessData;

    // Byte address splits into a word index and a byte offset inside the word;
    // only word-aligned accesses (offset zero) are allowed to touch the array.
    assign idx     = dir[ADDR_W-1:OFF_W];
    assign offset  = dir[OFF_W-1:0];
    assign aligned = (offset == '0);
    assign memRead = mem[idx];

    // State register for the clear engine. Reset lands in CLEAR so the array
    // is always swept to zero before the first access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Next-state logic. In IDLE a clr request wins over the access presented
    // in the same cycle. In CLEAR one word is zeroed per cycle; the counter
    // wraps back to zero on the last word so the next clear starts clean.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        busy      = 1'b0;
        clearWe   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    nextState = CLEAR;
                    nextCnt   = '0;
                end else begin
                    accept = 1'b1;
                end
            end
            CLEAR: begin
                busy    = 1'b1;
                clearWe = 1'b1;
                nextCnt = cnt + IDX_W'(1);
                if (cnt == LAST_IDX) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

`ifdef BYTE_WRITE_EN
    // With strobes, the word written back is the stored word with only the
    // strobed bytes replaced; the same merged word is what dataOut shows.
    always_comb begin
        writeWord = memRead;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) begin
                writeWord[b*8 +: 8] = dataIn[b*8 +: 8];
            end
        end
    end
`else
    assign writeWord = dataIn;
`endif

    assign takeAccess = accept && aligned;
    assign accessData = en ? writeWord : memRead;

    // Array write port. The clear engine owns the port while busy; otherwise
    // only accepted aligned writes land. No reset here: zeroing is the clear
    // engine's job, which keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (clearWe) begin
            mem[cnt] <= '0;
        end else if (takeAccess && en) begin
            mem[idx] <= writeWord;
        end
    end

    // Registered access outputs. An aligned accepted access loads dataOut
    // (write-first on writes) and clears alignErr; a misaligned one only
    // raises alignErr and leaves the data outputs untouched. Nothing changes
    // while busy or on the cycle a clear is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut  <= '0;
            zeroFlag <= 1'b1;
            alignErr <= 1'b0;
        end else if (accept) begin
            if (aligned) begin
                dataOut  <= accessData;
                zeroFlag <= (accessData == '0);
                alignErr <= 1'b0;
            end else begin
                alignErr <= 1'b1;
            end
        end
    end

endmodule
